// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator. It has a shared prescaler and counter, edge-
// or center-aligned counting, and double-buffered configuration that is
// applied only on period boundaries.
//
// dir | meaning
// ----+----------------------------------------------
// UP  | center mode, counter rising toward period_act
// DOWN| center mode, counter falling back toward 0
module pwm_multi_channel #(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*CNT_W-1:0]   duty,
  input  logic [CNT_W-1:0]          period,
  input  logic [PRESC_W-1:0]        presc,
  input  logic                      center_mode,
  input  logic                      load,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic                      cycle_start,
  output logic                      update_done
);

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  logic [NUM_CH*CNT_W-1:0] duty_sh_q, duty_act_q;
  logic [CNT_W-1:0]        period_sh_q, period_act_q;
  logic [PRESC_W-1:0]      presc_sh_q, presc_act_q;
  logic                    mode_sh_q, mode_act_q;
  logic                    pending_q;

  logic [PRESC_W-1:0]      presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  dir_e                    dir_q, dir_d;
  logic                    tick, boundary, apply;

  logic                    bnd_q, upd_q;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic                    cycle_start_q, update_done_q;

  // Prescaler, counter and direction next-state, plus boundary detection.
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    tick        = 1'b0;
    boundary    = 1'b0;
    if (!ena) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      dir_d       = DIR_UP;
    end else begin
      tick        = (presc_cnt_q == presc_act_q);
      presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
      if (tick) begin
        if (!mode_act_q) begin
          if (cnt_q == period_act_q) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (period_act_q == '0) begin
          // Degenerate center period: counter parks at 0, every tick wraps.
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          if (dir_q == DIR_UP) begin
            if (cnt_q == period_act_q) begin
              cnt_d = cnt_q - CNT_W'(1);
              dir_d = DIR_DOWN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (cnt_d == '0) begin
            boundary = 1'b1;
            dir_d    = DIR_UP;
          end
        end
      end
    end
    apply = boundary & pending_q;
    // A mode change at apply restarts counting upward from 0.
    if (apply) begin
      dir_d = DIR_UP;
    end
  end

  // Per-channel compare against the active duty.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = ena & ch_en[i] & (cnt_q < duty_act_q[i*CNT_W +: CNT_W]);
    end
  end

  // Counter state and output pipeline; pulses are delayed one extra stage so
  // they line up with the cnt = 0 compare appearing on pwm_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_q   <= '0;
      cnt_q         <= '0;
      dir_q         <= DIR_UP;
      bnd_q         <= 1'b0;
      upd_q         <= 1'b0;
      pwm_q         <= '0;
      cycle_start_q <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      presc_cnt_q   <= presc_cnt_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      bnd_q         <= boundary;
      upd_q         <= apply;
      pwm_q         <= pwm_d;
      cycle_start_q <= ena & bnd_q;
      update_done_q <= ena & upd_q;
    end
  end

  // Shadow capture on load, transfer to the active set on an applying boundary.
  // On a coincident load the active set takes the old shadow and pending stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh_q    <= '0;
      period_sh_q  <= '1;
      presc_sh_q   <= '0;
      mode_sh_q    <= 1'b0;
      duty_act_q   <= '0;
      period_act_q <= '1;
      presc_act_q  <= '0;
      mode_act_q   <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      if (apply) begin
        duty_act_q   <= duty_sh_q;
        period_act_q <= period_sh_q;
        presc_act_q  <= presc_sh_q;
        mode_act_q   <= mode_sh_q;
      end
      if (load) begin
        duty_sh_q   <= duty;
        period_sh_q <= period;
        presc_sh_q  <= presc;
        mode_sh_q   <= center_mode;
        pending_q   <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign cycle_start = cycle_start_q;
  assign update_done = update_done_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel. The reference model tracks the
// clock position inside the current period and derives the counter value
// from it arithmetically.
module tb_pwm_multi_channel;
  localparam int NUM_CH  = 8;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    ena;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic [CNT_W-1:0]        period;
  logic [PRESC_W-1:0]      presc;
  logic                    center_mode;
  logic                    load;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    cycle_start;
  logic                    update_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ch_en(ch_en), .duty(duty),
    .period(period), .presc(presc), .center_mode(center_mode), .load(load),
    .pwm_out(pwm_out), .cycle_start(cycle_start), .update_done(update_done)
  );

  // Reference model state
  int sh_duty[NUM_CH];
  int ac_duty[NUM_CH];
  int sh_per, ac_per, sh_presc, ac_presc;
  bit sh_mode, ac_mode, pend;
  int t;
  bit prev_bnd, prev_ud;

  function automatic int plen();
    return (ac_presc + 1) * (ac_mode ? ((ac_per == 0) ? 1 : 2 * ac_per) : ac_per + 1);
  endfunction

  function automatic int cnt_at(int tt);
    int k, m;
    k = tt / (ac_presc + 1);
    if (!ac_mode) return k % (ac_per + 1);
    if (ac_per == 0) return 0;
    m = k % (2 * ac_per);
    return (m <= ac_per) ? m : 2 * ac_per - m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      sh_duty[i] = 0;
      ac_duty[i] = 0;
    end
    sh_per = 255; ac_per = 255;
    sh_presc = 0; ac_presc = 0;
    sh_mode = 0; ac_mode = 0;
    pend = 0; t = 0; prev_bnd = 0; prev_ud = 0;
  endtask

  // Advance one clock with the currently driven inputs and check against the model.
  task automatic step();
    logic [NUM_CH-1:0] e_pwm;
    bit e_cs, e_ud, bnd;
    int c;
    c   = cnt_at(t);
    bnd = ena && (t == plen() - 1);
    for (int i = 0; i < NUM_CH; i++) e_pwm[i] = ena && ch_en[i] && (c < ac_duty[i]);
    e_cs = ena && prev_bnd;
    e_ud = ena && prev_ud;
    prev_ud  = bnd && pend;
    prev_bnd = bnd;
    if (!ena || bnd) t = 0; else t++;
    if (bnd && pend) begin
      for (int i = 0; i < NUM_CH; i++) ac_duty[i] = sh_duty[i];
      ac_per = sh_per; ac_presc = sh_presc; ac_mode = sh_mode; pend = 0;
    end
    if (load) begin
      for (int i = 0; i < NUM_CH; i++) sh_duty[i] = int'(duty[i*CNT_W +: CNT_W]);
      sh_per = int'(period); sh_presc = int'(presc); sh_mode = center_mode; pend = 1;
    end
    @(posedge clk); #1;
    checks++;
    if (pwm_out !== e_pwm) begin
      errors++;
      $display("FAIL model_pwm_out @%0t got=%b exp=%b", $time, pwm_out, e_pwm);
    end
    checks++;
    if (cycle_start !== e_cs) begin
      errors++;
      $display("FAIL model_cycle_start @%0t got=%b exp=%b", $time, cycle_start, e_cs);
    end
    checks++;
    if (update_done !== e_ud) begin
      errors++;
      $display("FAIL model_update_done @%0t got=%b exp=%b", $time, update_done, e_ud);
    end
  endtask

  task automatic do_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic set_duty(int ch, int v);
    duty[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic wait_ud(string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (update_done !== 1'b1 && n < 3000);
    checks++;
    if (update_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_update_done got=timeout exp=pulse", name);
    end
  endtask

  task automatic window(int n, output int h0, output int h1, output int cs, output int ud);
    h0 = 0; h1 = 0; cs = 0; ud = 0;
    repeat (n) begin
      step();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      cs += int'(cycle_start);
      ud += int'(update_done);
    end
  endtask

  task automatic test_reset();
    int h0, h1, cs, ud;
    rst_n = 1'b0; ena = 1'b1; ch_en = '1; duty = '0; period = 8'd9;
    presc = '0; center_mode = 1'b0; load = 1'b0;
    model_reset();
    #12;
    checks++;
    if (pwm_out !== '0) begin errors++; $display("FAIL reset_pwm_out got=%b exp=0", pwm_out); end
    checks++;
    if (cycle_start !== 1'b0) begin errors++; $display("FAIL reset_cycle_start got=%b exp=0", cycle_start); end
    checks++;
    if (update_done !== 1'b0) begin errors++; $display("FAIL reset_update_done got=%b exp=0", update_done); end
    @(negedge clk);
    rst_n = 1'b1;
    window(300, h0, h1, cs, ud);
    checks++;
    if (cs != 1) begin errors++; $display("FAIL reset_default_period cycle_starts got=%0d exp=1", cs); end
    checks++;
    if (h0 != 0) begin errors++; $display("FAIL reset_default_duty highs got=%0d exp=0", h0); end
  endtask

  task automatic test_edge();
    int h0, h1, cs, ud;
    period = 8'd9; presc = '0; center_mode = 1'b0; set_duty(0, 3);
    do_load();
    wait_ud("edge");
    window(20, h0, h1, cs, ud);
    checks++;
    if (h0 != 6) begin errors++; $display("FAIL edge_high_count got=%0d exp=6", h0); end
    checks++;
    if (cs != 2) begin errors++; $display("FAIL edge_cycle_start_count got=%0d exp=2", cs); end
  endtask

  task automatic test_prescaler();
    int h0, h1, cs, ud;
    presc = 4'd3;
    do_load();
    wait_ud("presc");
    window(40, h0, h1, cs, ud);
    checks++;
    if (h0 != 12) begin errors++; $display("FAIL presc_high_count got=%0d exp=12", h0); end
    checks++;
    if (cs != 1) begin errors++; $display("FAIL presc_cycle_start_count got=%0d exp=1", cs); end
  endtask

  task automatic test_center();
    int h0, h1, cs, ud;
    presc = '0; period = 8'd4; center_mode = 1'b1; set_duty(0, 2);
    do_load();
    wait_ud("center");
    window(16, h0, h1, cs, ud);
    checks++;
    if (h0 != 6) begin errors++; $display("FAIL center_high_count got=%0d exp=6", h0); end
    checks++;
    if (cs != 2) begin errors++; $display("FAIL center_cycle_start_count got=%0d exp=2", cs); end
  endtask

  task automatic test_duty_extremes();
    int h0, h1, cs, ud;
    period = 8'd9; center_mode = 1'b0; set_duty(0, 0); set_duty(1, 10); ch_en = 8'h03;
    do_load();
    wait_ud("extremes");
    window(20, h0, h1, cs, ud);
    checks++;
    if (h0 != 0) begin errors++; $display("FAIL duty_zero_highs got=%0d exp=0", h0); end
    checks++;
    if (h1 != 20) begin errors++; $display("FAIL duty_over_period_highs got=%0d exp=20", h1); end
  endtask

  task automatic test_shadow();
    int h0, h1, cs, ud, n;
    set_duty(0, 3);
    do_load();
    wait_ud("shadow_setup");
    repeat (4) step();
    set_duty(0, 7);
    do_load();
    wait_ud("shadow_apply");
    window(20, h0, h1, cs, ud);
    checks++;
    if (h0 != 14) begin errors++; $display("FAIL shadow_new_duty_highs got=%0d exp=14", h0); end
    checks++;
    if (ud != 0) begin errors++; $display("FAIL shadow_single_update got=%0d extra exp=0", ud); end
    n = 0;
    while (t != 3 && n < 100) begin step(); n++; end
    set_duty(0, 2);
    do_load();
    n = 0;
    while (t != plen() - 1 && n < 100) begin step(); n++; end
    checks++;
    if (t != plen() - 1) begin errors++; $display("FAIL coincident_find_boundary got=timeout exp=boundary"); end
    set_duty(0, 5);
    do_load();
    window(21, h0, h1, cs, ud);
    checks++;
    if (ud != 2) begin errors++; $display("FAIL coincident_update_count got=%0d exp=2", ud); end
    checks++;
    if (h0 != 8) begin errors++; $display("FAIL coincident_high_count got=%0d exp=8", h0); end
  endtask

  task automatic test_ena();
    int h0, h1, cs, ud;
    ena = 1'b0;
    repeat (5) begin
      step();
      checks++;
      if (pwm_out !== '0) begin errors++; $display("FAIL ena_low_pwm_out got=%b exp=0", pwm_out); end
    end
    ena = 1'b1;
    window(10, h0, h1, cs, ud);
    checks++;
    if (h0 != 5) begin errors++; $display("FAIL ena_restart_highs got=%0d exp=5", h0); end
    checks++;
    if (cs != 0) begin errors++; $display("FAIL ena_restart_cycle_start got=%0d exp=0", cs); end
  endtask

  task automatic test_reset_mid();
    int h0, h1, cs, ud;
    ch_en = '1;
    set_duty(0, 7);
    do_load();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== '0) begin errors++; $display("FAIL midreset_pwm_out got=%b exp=0", pwm_out); end
    checks++;
    if (cycle_start !== 1'b0 || update_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pulses got=%b%b exp=00", cycle_start, update_done);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    window(300, h0, h1, cs, ud);
    checks++;
    if (ud != 0) begin errors++; $display("FAIL midreset_pending_lost got=%0d exp=0", ud); end
    checks++;
    if (h0 != 0) begin errors++; $display("FAIL midreset_duty_cleared got=%0d exp=0", h0); end
    checks++;
    if (cs != 1) begin errors++; $display("FAIL midreset_cycle_start got=%0d exp=1", cs); end
  endtask

  task automatic test_random();
    repeat (800) begin
      ch_en = NUM_CH'($urandom);
      if ($urandom_range(0, 39) == 0) ena = 1'b0;
      else if ($urandom_range(0, 3) == 0) ena = 1'b1;
      load = ($urandom_range(0, 14) == 0);
      if (load) begin
        period      = CNT_W'($urandom_range(0, 12));
        presc       = PRESC_W'($urandom_range(0, 3));
        center_mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < NUM_CH; i++) duty[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 14));
      end
      step();
    end
    load = 1'b0;
    ena  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_prescaler();
    test_center();
    test_duty_extremes();
    test_shadow();
    test_ena();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
